// File: rtl/display_frame_datapath.sv
// Display pixel path: fills a frame buffer from the image reader in load mode and
// scans it out in raster order with programmable active/blanking timing in display mode.
module display_frame_datapath #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 10,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] WData,
  input  logic [CNT_W-1:0]  HBOut_PD,
  input  logic [CNT_W-1:0]  VBOut_PD,
  input  logic [CNT_W-1:0]  AIPOut_PD,
  input  logic [CNT_W-1:0]  AILOut_PD,
  input  logic              CSDisplay,
  output logic [DATA_W-1:0] PixelOut,
  output logic              DataEnable,
  output logic              HSync,
  output logic              VSync,
  output logic              FrameEnd
);

  localparam logic [CNT_W:0]    CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  rd_data;
  logic [CNT_W-1:0]   h_cnt, v_cnt;
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W:0]     line_len, frame_lines;
  logic [2*CNT_W-1:0] frame_prod;
  logic [ADDR_W-1:0]  frame_words;
  logic               h_wrap, v_wrap, active, wr_last;
  logic               de_q, hs_q, vs_q, fe_q;

  assign line_len    = {1'b0, AIPOut_PD} + {1'b0, HBOut_PD};
  assign frame_lines = {1'b0, AILOut_PD} + {1'b0, VBOut_PD};
  assign frame_prod  = AIPOut_PD * AILOut_PD;
  assign frame_words = frame_prod[ADDR_W-1:0];

  // ">=" wrap tests: a limit lowered mid-frame wraps on the next clock rather than overflowing
  assign h_wrap = ({1'b0, h_cnt} + CNT_ONE) >= line_len;
  assign v_wrap = ({1'b0, v_cnt} + CNT_ONE) >= frame_lines;
  assign active = (h_cnt < AIPOut_PD) && (v_cnt < AILOut_PD);

  assign wr_last = ((frame_words != '0) && (wr_ptr >= frame_words - ADDR_ONE)) ||
                   (wr_ptr == ADDR_TOP);

  always_ff @(posedge clk) begin
    if (!CSDisplay) mem[wr_ptr] <= WData;
  end

  always_ff @(posedge clk) begin
    if (CSDisplay && active) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      h_cnt  <= '0;
      v_cnt  <= '0;
      de_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else if (!CSDisplay) begin
      wr_ptr <= wr_last ? '0 : wr_ptr + ADDR_ONE;
      rd_ptr <= '0;
      h_cnt  <= '0;
      v_cnt  <= '0;
      de_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      wr_ptr <= '0;
      h_cnt  <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      if (h_wrap && v_wrap) rd_ptr <= '0;
      else if (active)      rd_ptr <= rd_ptr + ADDR_ONE;
      de_q <= active;
      hs_q <= (h_cnt >= AIPOut_PD);
      vs_q <= (v_cnt >= AILOut_PD);
      fe_q <= h_wrap && v_wrap;
    end
  end

  // read data has no reset; gating by the enable keeps the pixel bus at 0 out of reset
  assign PixelOut   = de_q ? rd_data : '0;
  assign DataEnable = de_q;
  assign HSync      = hs_q;
  assign VSync      = vs_q;
  assign FrameEnd   = fe_q;

endmodule

// File: tb/tb_display_frame_datapath.sv
// Directed bench for display_frame_datapath: loads known patterns and checks the
// scan-out against a raster-position model, including mode changes and reset.
module tb_display_frame_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] WData;
  logic [9:0]  HBOut_PD, VBOut_PD, AIPOut_PD, AILOut_PD;
  logic        CSDisplay;
  logic [31:0] PixelOut;
  logic        DataEnable, HSync, VSync, FrameEnd;

  int errors = 0;
  int checks = 0;
  int hs_total, vs_total, fe_total;

  display_frame_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .WData      (WData),
    .HBOut_PD   (HBOut_PD),
    .VBOut_PD   (VBOut_PD),
    .AIPOut_PD  (AIPOut_PD),
    .AILOut_PD  (AILOut_PD),
    .CSDisplay  (CSDisplay),
    .PixelOut   (PixelOut),
    .DataEnable (DataEnable),
    .HSync      (HSync),
    .VSync      (VSync),
    .FrameEnd   (FrameEnd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat2(input int i);
    return 32'h8000_0000 | 32'(i * 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pix"}, PixelOut, 32'd0);
    chk({tag, "_de"}, {31'd0, DataEnable}, 32'd0);
    chk({tag, "_hs"}, {31'd0, HSync}, 32'd0);
    chk({tag, "_vs"}, {31'd0, VSync}, 32'd0);
    chk({tag, "_fe"}, {31'd0, FrameEnd}, 32'd0);
  endtask

  // expected outputs for the counter position pos (0-based within the frame)
  task automatic chk_disp(input int pos, input int sel, input int aip, input int hb,
                          input int ail, input int vb);
    int line_len, h, v, idx;
    logic de, hs, vs, fe;
    logic [31:0] pix;
    line_len = aip + hb;
    h   = pos % line_len;
    v   = pos / line_len;
    de  = (h < aip) && (v < ail);
    hs  = (h >= aip);
    vs  = (v >= ail);
    fe  = (pos == line_len * (ail + vb) - 1);
    idx = v * aip + h;
    pix = de ? ((sel != 0) ? pat2(idx) : 32'(idx)) : 32'd0;
    chk("disp_pix", PixelOut, pix);
    chk("disp_de", {31'd0, DataEnable}, {31'd0, de});
    chk("disp_hs", {31'd0, HSync}, {31'd0, hs});
    chk("disp_vs", {31'd0, VSync}, {31'd0, vs});
    chk("disp_fe", {31'd0, FrameEnd}, {31'd0, fe});
  endtask

  initial begin
    reset     = 1'b0;
    CSDisplay = 1'b0;
    WData     = '0;
    AIPOut_PD = 10'd100;
    AILOut_PD = 10'd100;
    HBOut_PD  = 10'd10;
    VBOut_PD  = 10'd10;

    repeat (3) step();
    chk_idle("reset");
    reset = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      WData = 32'(i);
      step();
      if (i == 0) chk_idle("load");
    end

    CSDisplay = 1'b1;
    hs_total = 0;
    vs_total = 0;
    fe_total = 0;
    for (int k = 1; k <= 12320; k++) begin
      step();
      chk_disp((k - 1) % 12100, 0, 100, 10, 100, 10);
      if (k <= 12100) begin
        hs_total += int'(HSync);
        vs_total += int'(VSync);
        fe_total += int'(FrameEnd);
      end
    end
    chk("hsync_clocks_per_frame", 32'(hs_total), 32'd1100);
    chk("vsync_clocks_per_frame", 32'(vs_total), 32'd1100);
    chk("frameend_pulses", 32'(fe_total), 32'd1);

    for (int k = 12321; k <= 12357; k++) begin
      step();
      chk_disp((k - 1) % 12100, 0, 100, 10, 100, 10);
    end

    CSDisplay = 1'b0;
    WData = pat2(0);
    step();
    chk_idle("drop");
    for (int i = 1; i < 10000; i++) begin
      WData = pat2(i);
      step();
    end

    CSDisplay = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      step();
      chk_disp(k - 1, 1, 100, 10, 100, 10);
    end

    #2 reset = 1'b0;
    #1 chk_idle("async_rst");
    step();
    chk_idle("rst_held");
    reset = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      step();
      chk_disp(k - 1, 1, 100, 10, 100, 10);
    end

    HBOut_PD = 10'd0;
    VBOut_PD = 10'd0;
    #2 reset = 1'b0;
    #1 chk_idle("rst_noblank");
    step();
    reset = 1'b1;
    for (int k = 1; k <= 10050; k++) begin
      step();
      chk_disp((k - 1) % 10000, 1, 100, 0, 100, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_frame_datapath.md
Name: display_frame_datapath

Overview:
- Pixel data path of the display adapter.
- When the display is not selected (CSDisplay=0), the block stores the incoming 32-bit pixel stream from the image reader into an internal frame buffer.
- When the display is selected (CSDisplay=1), it scans the buffer out in raster order. Timing is programmable: active pixels per line, horizontal blanking, active lines and vertical blanking.
- It produces pixel data, data-enable and sync outputs for the panel interface.

Parameters:
- DATA_W, 32, pixel word width.
- CNT_W, 10, width of the timing inputs and the h/v counters.
- ADDR_W, 14, frame buffer address width.
- DEPTH, 16384, frame buffer words; must be at least AIPOut_PD*AILOut_PD (10000 for 100x100).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- WData  in  DATA_W  pixel word from the image reader, one per clock.
- HBOut_PD  in  CNT_W  horizontal blanking length, in pixel clocks.
- VBOut_PD  in  CNT_W  vertical blanking length, in lines.
- AIPOut_PD  in  CNT_W  active image pixels per line.
- AILOut_PD  in  CNT_W  active image lines per frame.
- CSDisplay  in  1  0 = load frame buffer, 1 = display/scan-out.
- PixelOut  out  DATA_W  scanned-out pixel; 0 outside the active area.
- DataEnable  out  1  high when PixelOut is an active-area pixel.
- HSync  out  1  high during horizontal blanking.
- VSync  out  1  high during vertical blanking lines.
- FrameEnd  out  1  one-cycle pulse on the last pixel clock of a frame.

Behaviour:
- Reset (reset=0, asynchronous): write pointer, read pointer, h_cnt and v_cnt go to 0. PixelOut, DataEnable, HSync, VSync and FrameEnd go to 0. Buffer contents are not cleared.
- Load mode (CSDisplay=0):
  - Every clock: mem[wr_ptr] <= WData, then wr_ptr increments.
  - wr_ptr wraps to 0 after AIPOut_PD*AILOut_PD-1; it also wraps modulo DEPTH.
  - h_cnt, v_cnt and rd_ptr are held at 0; all outputs are 0.
- Display mode (CSDisplay=1):
  - wr_ptr is held at 0, so the next load starts at address 0.
  - h_cnt counts 0..AIP+HB-1, then wraps to 0 and increments v_cnt.
  - v_cnt counts 0..AIL+VB-1, then wraps to 0.
  - active = (h_cnt < AIP) and (v_cnt < AIL).
  - When active, the buffer is read at rd_ptr and rd_ptr increments. rd_ptr returns to 0 at frame wrap, so pixels come out in the order they were written.
- Output timing:
  - The buffer read is synchronous, so PixelOut, DataEnable, HSync, VSync and FrameEnd are all registered one cycle after the counter state that produced them. All outputs stay mutually aligned.
  - HSync = (h_cnt >= AIP).
  - VSync = (v_cnt >= AIL).
  - FrameEnd = (h_cnt = AIP+HB-1) and (v_cnt = AIL+VB-1).
- Timing rates: line period is AIP+HB clocks; frame period is (AIP+HB)*(AIL+VB) clocks. With 100/10/100/10 this gives 110 clocks per line and 12100 clocks per frame.
- Mode change:
  - Display to load (CSDisplay 1->0): counters and rd_ptr reset to 0 on that clock edge; outputs are 0 from the next cycle.
  - Load to display (CSDisplay 0->1): scan starts at h=0, v=0; the first pixel mem[0] appears on PixelOut one cycle later.
- Timing inputs are sampled every cycle. Wrap tests use ">=" comparisons, so a reduced limit mid-frame wraps on the next clock instead of overflowing.
- AIP=0 or AIL=0: DataEnable is never asserted and the sync outputs follow the blanking rules.
- Arithmetic: comparisons use CNT_W+1 bits, so AIP+HB cannot overflow. The AIP*AIL product uses ADDR_W bits.

Test Plan:
- Reset, then drive reset low mid-display -> all outputs 0 immediately (no clock needed); the counters restart at 0 after release.
- Load 10000 words with WData=index (AIP=AIL=100, HB=VB=10), then set CSDisplay=1. Expected:
  - PixelOut = 0,1,2..99 with DataEnable=1 on cycles 1..100 after the switch.
  - PixelOut=0 and DataEnable=0 for the next 10 cycles.
- Line timing in display mode -> HSync high for exactly 10 of every 110 clocks. Line 1 shows pixels 100..199.
- Frame timing -> VSync high for lines 100..109 (1100 clocks). FrameEnd pulses once per 12100 clocks. Frame 2 starts again with pixel 0.
- CSDisplay dropped mid-line, load a new 10000-word pattern, re-enable -> the new pattern scans from pixel 0 and line 0.
- HB=0, VB=0 -> DataEnable continuously high. HSync and VSync are never asserted.
